// File: rtl/spi_display_sequencer.sv
// Sequences LCD hardware reset, the init engine and the picture engine, and
// arbitrates the shared panel SPI pins between the two engines.
//
// state      | meaning
// IDLE       | waiting for i_start, panel pins idle
// RST_LOW    | panel reset pin held low
// RST_WAIT   | panel reset released, settling before init
// INIT_START | one-cycle start pulse to the init engine
// INIT_RUN   | init engine owns the SPI pins, waiting for done
// PIC_START  | one-cycle start pulse to the picture engine
// PIC_RUN    | picture engine owns the SPI pins, waiting for done
// READY      | panel running, waiting for redraw or refresh
// ERROR      | an engine timed out, waiting for i_start
`timescale 1ns/1ps
module spi_display_sequencer #(
    parameter int RST_LOW_CYC  = 20,
    parameter int RST_WAIT_CYC = 20,
    parameter int REFRESH_CYC  = 0,
    parameter int TIMEOUT_CYC  = 1000000,
    parameter int CNT_W        = 24
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_redraw,
    output logic o_init_start,
    input  logic i_init_done,
    input  logic i_init_mosi,
    input  logic i_init_dc,
    input  logic i_init_cs,
    output logic o_pic_start,
    input  logic i_pic_done,
    input  logic i_pic_mosi,
    input  logic i_pic_dc,
    input  logic i_pic_cs,
    output logic o_mosi,
    output logic o_dc,
    output logic o_cs,
    output logic o_lcd_rst,
    output logic o_busy,
    output logic o_ready,
    output logic o_done,
    output logic o_error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_LOW,
        S_RST_WAIT,
        S_INIT_START,
        S_INIT_RUN,
        S_PIC_START,
        S_PIC_RUN,
        S_READY,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INIT,
        OWN_PIC
    } owner_t;

    // Counter value on the last cycle of each timed dwell; 0 or 1 both mean one cycle.
    localparam int LOW_LAST_I     = (RST_LOW_CYC  > 1) ? RST_LOW_CYC  - 1 : 0;
    localparam int WAIT_LAST_I    = (RST_WAIT_CYC > 1) ? RST_WAIT_CYC - 1 : 0;
    localparam int REFRESH_LAST_I = (REFRESH_CYC  > 1) ? REFRESH_CYC  - 1 : 0;
    localparam int TIMEOUT_LAST_I = (TIMEOUT_CYC  > 1) ? TIMEOUT_CYC  - 1 : 0;

    localparam logic [CNT_W-1:0] LOW_LAST     = CNT_W'(LOW_LAST_I);
    localparam logic [CNT_W-1:0] WAIT_LAST    = CNT_W'(WAIT_LAST_I);
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_LAST_I);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    localparam bit REFRESH_EN = (REFRESH_CYC != 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0);

    state_t           state;
    state_t           state_next;
    owner_t           owner;
    owner_t           owner_next;
    logic [CNT_W-1:0] cnt;
    logic             timed_out;
    logic             refresh_due;

    assign timed_out   = TIMEOUT_EN && (cnt == TIMEOUT_LAST);
    assign refresh_due = REFRESH_EN && (cnt == REFRESH_LAST);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_IDLE;
            owner <= OWN_NONE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            if (state_next != state) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (i_start) state_next = S_RST_LOW;
            end
            S_RST_LOW: begin
                if (cnt == LOW_LAST) state_next = S_RST_WAIT;
            end
            S_RST_WAIT: begin
                if (cnt == WAIT_LAST) state_next = S_INIT_START;
            end
            S_INIT_START: begin
                state_next = S_INIT_RUN;
            end
            S_INIT_RUN: begin
                if (i_init_done)    state_next = S_PIC_START;
                else if (timed_out) state_next = S_ERROR;
            end
            S_PIC_START: begin
                state_next = S_PIC_RUN;
            end
            S_PIC_RUN: begin
                if (i_pic_done)     state_next = S_READY;
                else if (timed_out) state_next = S_ERROR;
            end
            S_READY: begin
                // A start request outranks a redraw arriving in the same cycle.
                if (i_start)          state_next = S_RST_LOW;
                else if (i_redraw)    state_next = S_PIC_START;
                else if (refresh_due) state_next = S_PIC_START;
            end
            S_ERROR: begin
                if (i_start) state_next = S_RST_LOW;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        owner_next = OWN_NONE;
        case (state_next)
            S_INIT_START, S_INIT_RUN: owner_next = OWN_INIT;
            S_PIC_START,  S_PIC_RUN:  owner_next = OWN_PIC;
            default:                  owner_next = OWN_NONE;
        endcase
    end

    // Pin mux is purely combinational so engine pins reach the panel with no added latency.
    always_comb begin
        o_mosi = 1'b0;
        o_dc   = 1'b0;
        o_cs   = 1'b1;
        case (owner)
            OWN_INIT: begin
                o_mosi = i_init_mosi;
                o_dc   = i_init_dc;
                o_cs   = i_init_cs;
            end
            OWN_PIC: begin
                o_mosi = i_pic_mosi;
                o_dc   = i_pic_dc;
                o_cs   = i_pic_cs;
            end
            default: begin
                o_mosi = 1'b0;
                o_dc   = 1'b0;
                o_cs   = 1'b1;
            end
        endcase
    end

    assign o_lcd_rst    = (state != S_RST_LOW);
    assign o_init_start = (state == S_INIT_START);
    assign o_pic_start  = (state == S_PIC_START);
    assign o_busy       = (state != S_IDLE) && (state != S_READY) && (state != S_ERROR);
    assign o_ready      = (state == S_READY);
    assign o_done       = (state == S_READY) && (cnt == '0);
    assign o_error      = (state == S_ERROR);

endmodule

// File: tb/tb_spi_display_sequencer.sv
// Bench for spi_display_sequencer: per-cycle vector table for bring-up/mux/redraw,
// hand sequences for timeout, async reset and auto-refresh, pulse scoreboard.
`timescale 1ns/1ps
module tb_spi_display_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // dut0: no auto-refresh
    logic rst_n, start, redraw, idone, imosi, idc, ics, pdone, pmosi, pdc, pcs;
    logic init_start0, pic_start0, mosi0, dc0, cs0, lcd_rst0, busy0, ready0, done0, error0;

    // dut1: auto-refresh every 8 cycles
    logic r_rst, r_start, r_idone, r_pdone;
    logic init_start1, pic_start1, mosi1, dc1, cs1, lcd_rst1, busy1, ready1, done1, error1;

    spi_display_sequencer #(
        .RST_LOW_CYC(4), .RST_WAIT_CYC(3), .REFRESH_CYC(0), .TIMEOUT_CYC(50), .CNT_W(24)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_redraw(redraw),
        .o_init_start(init_start0), .i_init_done(idone),
        .i_init_mosi(imosi), .i_init_dc(idc), .i_init_cs(ics),
        .o_pic_start(pic_start0), .i_pic_done(pdone),
        .i_pic_mosi(pmosi), .i_pic_dc(pdc), .i_pic_cs(pcs),
        .o_mosi(mosi0), .o_dc(dc0), .o_cs(cs0), .o_lcd_rst(lcd_rst0),
        .o_busy(busy0), .o_ready(ready0), .o_done(done0), .o_error(error0)
    );

    spi_display_sequencer #(
        .RST_LOW_CYC(4), .RST_WAIT_CYC(3), .REFRESH_CYC(8), .TIMEOUT_CYC(50), .CNT_W(24)
    ) dut_r (
        .i_clk(clk), .i_rst(r_rst), .i_start(r_start), .i_redraw(1'b0),
        .o_init_start(init_start1), .i_init_done(r_idone),
        .i_init_mosi(1'b0), .i_init_dc(1'b0), .i_init_cs(1'b1),
        .o_pic_start(pic_start1), .i_pic_done(r_pdone),
        .i_pic_mosi(1'b0), .i_pic_dc(1'b0), .i_pic_cs(1'b1),
        .o_mosi(mosi1), .o_dc(dc1), .o_cs(cs1), .o_lcd_rst(lcd_rst1),
        .o_busy(busy1), .o_ready(ready1), .o_done(done1), .o_error(error1)
    );

    // {lcd_rst, init_start, pic_start, busy, ready, done, error, mosi, dc, cs}
    function automatic logic [9:0] outs0();
        return {lcd_rst0, init_start0, pic_start0, busy0, ready0, done0, error0, mosi0, dc0, cs0};
    endfunction

    function automatic logic [9:0] outs1();
        return {lcd_rst1, init_start1, pic_start1, busy1, ready1, done1, error1, mosi1, dc1, cs1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse scoreboard: kind 0 = init_start, 1 = pic_start, 2 = done
    typedef struct {
        int kind;
        int cyc;
    } ev_t;
    ev_t q0[$];
    ev_t q1[$];

    task automatic expect_ev(input int d, input int kind);
        ev_t e;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d_unexpected_pulse: got kind %0d at cycle %0d expected none", d, kind, cyc);
        end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("dut%0d_pulse_kind", d), kind, e.kind);
            check($sformatf("dut%0d_pulse_cycle", d), cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (init_start0) expect_ev(0, 0);
        if (pic_start0)  expect_ev(0, 1);
        if (done0)       expect_ev(0, 2);
        if (init_start1) expect_ev(1, 0);
        if (pic_start1)  expect_ev(1, 1);
        if (done1)       expect_ev(1, 2);
    end

    typedef struct {
        int         reps;
        logic [3:0] in;   // {start, redraw, init_done, pic_done}
        logic [9:0] exp;
    } vec_t;

    localparam logic [9:0] V_RST_LOW  = 10'b0_0_0_1_0_0_0_0_0_1;
    localparam logic [9:0] V_RST_WAIT = 10'b1_0_0_1_0_0_0_0_0_1;
    localparam logic [9:0] V_INIT_ST  = 10'b1_1_0_1_0_0_0_1_1_0;
    localparam logic [9:0] V_INIT_RUN = 10'b1_0_0_1_0_0_0_1_1_0;
    localparam logic [9:0] V_PIC_ST   = 10'b1_0_1_1_0_0_0_0_0_0;
    localparam logic [9:0] V_PIC_RUN  = 10'b1_0_0_1_0_0_0_0_0_0;
    localparam logic [9:0] V_READY_E  = 10'b1_0_0_0_1_1_0_0_0_1;
    localparam logic [9:0] V_READY    = 10'b1_0_0_0_1_0_0_0_0_1;
    localparam logic [9:0] V_IDLE     = 10'b1_0_0_0_0_0_0_0_0_1;
    localparam logic [9:0] V_ERROR    = 10'b1_0_0_0_0_0_1_0_0_1;

    vec_t vec[17];

    initial begin
        vec[0]  = '{1, 4'b1000, V_RST_LOW};
        vec[1]  = '{3, 4'b0000, V_RST_LOW};
        vec[2]  = '{3, 4'b0000, V_RST_WAIT};
        vec[3]  = '{1, 4'b0000, V_INIT_ST};
        vec[4]  = '{1, 4'b0000, V_INIT_RUN};
        vec[5]  = '{1, 4'b0001, V_INIT_RUN};   // stray pic done ignored
        vec[6]  = '{8, 4'b0000, V_INIT_RUN};
        vec[7]  = '{1, 4'b0010, V_PIC_ST};
        vec[8]  = '{1, 4'b0000, V_PIC_RUN};
        vec[9]  = '{3, 4'b0000, V_PIC_RUN};
        vec[10] = '{1, 4'b0001, V_READY_E};
        vec[11] = '{1, 4'b0010, V_READY};      // stray init done ignored
        vec[12] = '{2, 4'b0000, V_READY};
        vec[13] = '{1, 4'b0100, V_PIC_ST};
        vec[14] = '{2, 4'b0000, V_PIC_RUN};
        vec[15] = '{1, 4'b0001, V_READY_E};
        vec[16] = '{1, 4'b1100, V_RST_LOW};    // start beats redraw

        rst_n = 1'b0; r_rst = 1'b0;
        start = 1'b0; redraw = 1'b0; idone = 1'b0; pdone = 1'b0;
        imosi = 1'b1; idc = 1'b1; ics = 1'b0;
        pmosi = 1'b0; pdc = 1'b0; pcs = 1'b0;
        r_start = 1'b0; r_idone = 1'b0; r_pdone = 1'b0;

        #1;
        check("reset_outputs_dut0", outs0(), V_IDLE);
        check("reset_outputs_dut1", outs1(), V_IDLE);
        step();
        step();
        rst_n = 1'b1; r_rst = 1'b1;
        step();
        check("idle_after_release", outs0(), V_IDLE);

        // bring-up, mux, stray dones, redraw, start-vs-redraw
        for (int i = 0; i < 17; i++) begin
            for (int r = 0; r < vec[i].reps; r++) begin
                {start, redraw, idone, pdone} = vec[i].in;
                if (vec[i].exp[8]) q0.push_back('{kind: 0, cyc: cyc + 1});
                if (vec[i].exp[7]) q0.push_back('{kind: 1, cyc: cyc + 1});
                if (vec[i].exp[4]) q0.push_back('{kind: 2, cyc: cyc + 1});
                step();
                check($sformatf("vec%0d_rep%0d", i, r), outs0(), vec[i].exp);
            end
        end
        {start, redraw, idone, pdone} = 4'b0000;

        // timeout: now first cycle of RST_LOW, init start 7 cycles on
        q0.push_back('{kind: 0, cyc: cyc + 7});
        repeat (7) step();
        repeat (50) step();
        check("timeout_not_early", outs0(), V_INIT_RUN);
        step();
        check("timeout_error", outs0(), V_ERROR);
        redraw = 1'b1;
        step();
        redraw = 1'b0;
        check("error_ignores_redraw", outs0(), V_ERROR);
        start = 1'b1;
        step();
        start = 1'b0;
        check("error_restart", outs0(), V_RST_LOW);

        // async reset mid PIC_RUN
        q0.push_back('{kind: 0, cyc: cyc + 7});
        repeat (8) step();
        idone = 1'b1;
        q0.push_back('{kind: 1, cyc: cyc + 1});
        step();
        idone = 1'b0;
        step();
        imosi = 1'b0; idc = 1'b0; ics = 1'b1;
        pmosi = 1'b1; pdc = 1'b1; pcs = 1'b0;
        #1;
        check("pic_mux_live", {mosi0, dc0, cs0}, 3'b110);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs0(), V_IDLE);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("idle_after_async_reset", outs0(), V_IDLE);
        start = 1'b1;
        q0.push_back('{kind: 0, cyc: cyc + 8});
        step();
        start = 1'b0;
        check("restart_after_reset", outs0(), V_RST_LOW);
        repeat (8) step();
        rst_n = 1'b0;

        // auto-refresh on dut_r
        r_start = 1'b1;
        q1.push_back('{kind: 0, cyc: cyc + 8});
        step();
        r_start = 1'b0;
        repeat (8) step();
        r_idone = 1'b1;
        q1.push_back('{kind: 1, cyc: cyc + 1});
        step();
        r_idone = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            r_pdone = 1'b1;
            q1.push_back('{kind: 2, cyc: cyc + 1});
            q1.push_back('{kind: 1, cyc: cyc + 9});
            step();
            r_pdone = 1'b0;
            check($sformatf("refresh_ready_%0d", k), ready1, 1'b1);
            repeat (7) step();
            check($sformatf("refresh_still_ready_%0d", k), ready1, 1'b1);
            step();
            check($sformatf("refresh_pic_start_%0d", k), pic_start1, 1'b1);
            step();
        end
        step();

        check("scoreboard_dut0_drained", q0.size(), 0);
        check("scoreboard_dut1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_display_sequencer.md
# spi_display_sequencer

Top-level controller for the SPI LCD path. It drives the panel hardware-reset pin and sequences the panel-initialisation engine and then the picture engine through start/done handshakes. It arbitrates the single SPI pin set (mosi/dc/cs) between those two engines and handles redraw requests and timeouts once the panel is running. It sits between the board top and the two SPI engines, which never drive the panel pins directly.

## Interface
- RST_LOW_CYC, 20: cycles `o_lcd_rst` is held low.
- RST_WAIT_CYC, 20: cycles to wait after releasing `o_lcd_rst`, before init starts.
- REFRESH_CYC, 0: auto-redraw period in READY; 0 disables auto-redraw.
- TIMEOUT_CYC, 1000000: maximum cycles in INIT_RUN or PIC_RUN; 0 disables the timeout.
- CNT_W, 24: width of the shared cycle counter; must hold the largest parameter.
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst  in  1  reset; asynchronous, active-low.
- i_start  in  1  one-cycle pulse that begins the full sequence.
- i_redraw  in  1  one-cycle pulse requesting a picture redraw.
- o_init_start  out  1  one-cycle start pulse to the init engine.
- i_init_done  in  1  init engine completion.
- i_init_mosi, i_init_dc, i_init_cs  in  1 each  init engine SPI pins.
- o_pic_start  out  1  one-cycle start pulse to the picture engine.
- i_pic_done  in  1  picture engine completion.
- i_pic_mosi, i_pic_dc, i_pic_cs  in  1 each  picture engine SPI pins.
- o_mosi, o_dc, o_cs  out  1 each  panel SPI pins.
- o_lcd_rst  out  1  panel reset; active-low.
- o_busy  out  1  high in every state except IDLE, READY and ERROR.
- o_ready  out  1  high in READY.
- o_done  out  1  one-cycle pulse on each entry to READY.
- o_error  out  1  high in ERROR.

## Operation
- States: IDLE, RST_LOW, RST_WAIT, INIT_START, INIT_RUN, PIC_START, PIC_RUN, READY, ERROR.
- IDLE --i_start--> RST_LOW.
- RST_LOW: `o_lcd_rst`=0. When the counter expires --> RST_WAIT.
- RST_WAIT: `o_lcd_rst`=1. When the counter expires --> INIT_START.
- INIT_START: `o_init_start`=1 for exactly one cycle --> INIT_RUN.
- INIT_RUN: `i_init_done` --> PIC_START.
- PIC_START: `o_pic_start`=1 for one cycle --> PIC_RUN.
- PIC_RUN: `i_pic_done` --> READY.
- READY: `i_redraw`, or refresh counter expiry when REFRESH_CYC>0 --> PIC_START.
- i_start in READY or ERROR --> RST_LOW (full re-sequence).
- i_start and i_redraw in the same cycle: i_start wins.
- Timeout: in INIT_RUN or PIC_RUN, if the counter reaches TIMEOUT_CYC without done --> ERROR.
- ERROR: `o_cs`=1; leaves only via i_start.
- Ignored inputs (not latched):
  - i_start in any busy state.
  - i_redraw outside READY.
  - done inputs outside their RUN state.
- Counter: one CNT_W counter, cleared on every state change, incremented otherwise. It saturates; it never wraps.
- SPI arbitration uses an owner register, set on entry to the START states:
  - INIT_START/INIT_RUN: owner INIT.
  - PIC_START/PIC_RUN: owner PIC.
  - All other states: owner NONE.
- Pin mux is combinational from the owner register:
  - Owner INIT or PIC: o_mosi/o_dc/o_cs = that engine's pins, with zero added latency.
  - Owner NONE: o_cs=1, o_mosi=0, o_dc=0.
  - A non-owner engine's pins never reach the panel.

## Timing
- Reset values: state IDLE, o_lcd_rst=1, o_cs=1, o_mosi=0, o_dc=0, and all other outputs 0. Reset takes effect immediately and asynchronously, mid-operation included; the SPI pins go idle at once.
- i_start sampled at edge N: RST_LOW from N+1, o_lcd_rst low exactly RST_LOW_CYC cycles, then high for RST_WAIT_CYC cycles before o_init_start.
- Parameter values of 0 or 1 for RST_LOW_CYC or RST_WAIT_CYC give a 1-cycle minimum state dwell.
- o_init_start / o_pic_start are registered and last exactly 1 cycle.
- Done sampled at edge M in a RUN state: the next state is entered at M+1.
  - PIC_RUN done: o_done=1 and o_ready=1 in cycle M+1; o_done drops at M+2.
- Redraw latency: i_redraw sampled at edge K in READY gives o_pic_start high in cycle K+1.
- Refresh: the counter restarts on READY entry; PIC_START is entered after REFRESH_CYC cycles in READY.

## Test plan
- Bring-up (RST_LOW_CYC=4, RST_WAIT_CYC=3, TIMEOUT_CYC=50): pulse i_start → o_lcd_rst low 4 cycles then high 3 → one-cycle o_init_start. Assert i_init_done 10 cycles later → o_pic_start → assert i_pic_done → o_done one pulse, o_ready=1.
- Mux: drive init pins 1/1/0 and pic pins 0/0/0.
  - INIT_RUN → o_mosi=1, o_dc=1, o_cs=0.
  - READY → o_cs=1, o_mosi=0, o_dc=0 regardless of engine pins.
  - Stray i_pic_done during INIT_RUN → ignored.
- Redraw: in READY pulse i_redraw → o_pic_start next cycle, o_ready=0, o_busy=1. i_redraw and i_start in the same cycle → RST_LOW entered.
- Timeout: withhold i_init_done → ERROR after 50 cycles in INIT_RUN, o_error=1, o_cs=1. i_redraw → no effect. i_start → o_error=0, o_lcd_rst low.
- Auto-refresh (REFRESH_CYC=8): after o_done, o_pic_start is seen 8 cycles after READY entry and repeats after each picture completes.
- Async reset: drive i_rst=0 mid-PIC_RUN → outputs return to reset values immediately without a clock edge. Release → IDLE; i_start restarts the full sequence.
